// File: rtl/wb_regfile_pkg.sv
// Shared widths, write-back select and load funct3 encodings, and the MEM/WB latch layout.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_LOAD    = 2'b01,
        WB_PC4     = 2'b10,
        WB_ALU_ALT = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              reg_write;
        logic [ADDR_W-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        wb_select;
        logic [XLEN-1:0]   data;
    } wb_bundle_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the mem/decode stages (master) and the write-back register file (slave).
interface wb_regfile_if;
    import wb_pkg::*;

    logic              in_valid;
    logic [1:0]        in_wb_select;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_data;
    logic [ADDR_W-1:0] in_rd;
    logic              in_reg_write;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_value;
    logic [63:0]       retire_cnt;

    modport master (
        output in_valid, in_wb_select, in_funct3, in_data, in_rd, in_reg_write,
        output stall, flush, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_value, retire_cnt
    );

    modport slave (
        input  in_valid, in_wb_select, in_funct3, in_data, in_rd, in_reg_write,
        input  stall, flush, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_value, retire_cnt
    );

endinterface

// File: rtl/wb_regfile_load_ext.sv
// Combinational load-result extender; only the load select is reshaped by funct3.
module load_ext
    import wb_pkg::*;
(
    input  logic [1:0]      wb_select_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        if (wb_select_i == WB_LOAD) begin
            case (funct3_i)
                F3_LB:   ext_o = {{(XLEN-8){data_i[7]}},   data_i[7:0]};
                F3_LH:   ext_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
                F3_LW:   ext_o = {{(XLEN-32){data_i[31]}}, data_i[31:0]};
                F3_LBU:  ext_o = {{(XLEN-8){1'b0}},        data_i[7:0]};
                F3_LHU:  ext_o = {{(XLEN-16){1'b0}},       data_i[15:0]};
                F3_LWU:  ext_o = {{(XLEN-32){1'b0}},       data_i[31:0]};
                default: ext_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB latch, load extension, 32x64 integer register file and retired-instruction counter.
// Optional WB_BYPASS_EN: read ports see the in-flight write-back value in its fire cycle.
module wb_regfile
    import wb_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst,
    wb_regfile_if.slave  bus
);

    wb_bundle_t      latch_q, latch_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [63:0]     retire_q;
    logic [XLEN-1:0] ext_value;
    logic            fire;
    logic            wr_en;

    load_ext u_load_ext (
        .wb_select_i (latch_q.wb_select),
        .funct3_i    (latch_q.funct3),
        .data_i      (latch_q.data),
        .ext_o       (ext_value)
    );

    // done keeps a stalled entry from writing/retiring more than once
    assign fire  = latch_q.valid & ~latch_q.done;
    assign wr_en = fire & latch_q.reg_write & (latch_q.rd != '0);

    always_comb begin
        latch_d = latch_q;
        if (bus.flush) begin
            latch_d.valid = 1'b0;
        end else if (bus.stall) begin
            latch_d.done = latch_q.done | fire;
        end else begin
            latch_d.valid     = bus.in_valid;
            latch_d.done      = 1'b0;
            latch_d.reg_write = bus.in_reg_write;
            latch_d.rd        = bus.in_rd;
            latch_d.funct3    = bus.in_funct3;
            latch_d.wb_select = bus.in_wb_select;
            latch_d.data      = bus.in_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            latch_q  <= '0;
            retire_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            latch_q <= latch_d;
            if (fire) begin
                retire_q <= retire_q + 64'd1;
            end
            if (wr_en) begin
                regs_q[latch_q.rd] <= ext_value;
            end
        end
    end

    always_comb begin
        bus.rs1_data = (bus.rs1_addr == '0) ? '0 : regs_q[bus.rs1_addr];
        bus.rs2_data = (bus.rs2_addr == '0) ? '0 : regs_q[bus.rs2_addr];
`ifdef WB_BYPASS_EN
        // wr_en already excludes x0, so the bypass never exposes a value at address 0
        if (wr_en && (bus.rs1_addr == latch_q.rd)) begin
            bus.rs1_data = ext_value;
        end
        if (wr_en && (bus.rs2_addr == latch_q.rd)) begin
            bus.rs2_data = ext_value;
        end
`endif
    end

    assign bus.fwd_valid  = wr_en;
    assign bus.fwd_rd     = latch_q.rd;
    assign bus.fwd_value  = ext_value;
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: extension table, x0, stall, flush, bypass timing and reset.
module tb_wb_regfile;
    import wb_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   fwd_hits;

    wb_regfile_if bus ();

    wb_regfile dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid     = 1'b0;
        bus.in_wb_select = 2'b00;
        bus.in_funct3    = 3'b000;
        bus.in_data      = '0;
        bus.in_rd        = '0;
        bus.in_reg_write = 1'b0;
    endtask

    task automatic drive_instr(input logic [1:0] sel, input logic [2:0] f3,
                               input logic [63:0] data, input logic [4:0] rd);
        bus.in_valid     = 1'b1;
        bus.in_wb_select = sel;
        bus.in_funct3    = f3;
        bus.in_data      = data;
        bus.in_rd        = rd;
        bus.in_reg_write = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 3'b000, 64'hDEAD_BEEF_0000_0080, 5'd5,  64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{2'b01, 3'b100, 64'hDEAD_BEEF_0000_0080, 5'd6,  64'h0000_0000_0000_0080};
        vecs[2]  = '{2'b01, 3'b001, 64'h0000_0000_0001_8001, 5'd10, 64'hFFFF_FFFF_FFFF_8001};
        vecs[3]  = '{2'b01, 3'b101, 64'h0000_0000_0001_8001, 5'd11, 64'h0000_0000_0000_8001};
        vecs[4]  = '{2'b01, 3'b010, 64'h1234_5678_8000_0001, 5'd12, 64'hFFFF_FFFF_8000_0001};
        vecs[5]  = '{2'b01, 3'b110, 64'h1234_5678_8000_0001, 5'd13, 64'h0000_0000_8000_0001};
        vecs[6]  = '{2'b01, 3'b011, 64'h8123_4567_89AB_CDEF, 5'd14, 64'h8123_4567_89AB_CDEF};
        vecs[7]  = '{2'b10, 3'b000, 64'h0000_0000_0000_1084, 5'd15, 64'h0000_0000_0000_1084};
        vecs[8]  = '{2'b00, 3'b000, 64'h0000_0000_0000_0080, 5'd16, 64'h0000_0000_0000_0080};
        vecs[9]  = '{2'b11, 3'b100, 64'hFFFF_0000_0000_00FF, 5'd17, 64'hFFFF_0000_0000_00FF};
        vecs[10] = '{2'b01, 3'b111, 64'h8000_0000_0000_007F, 5'd18, 64'h8000_0000_0000_007F};
        vecs[11] = '{2'b01, 3'b000, 64'hFFFF_FFFF_FFFF_FF7F, 5'd19, 64'h0000_0000_0000_007F};
        vecs[12] = '{2'b01, 3'b001, 64'h0000_0000_0000_7FFF, 5'd31, 64'h0000_0000_0000_7FFF};

        drive_idle();
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd5;

        // reset for two cycles
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        #1;
        chk("rst_rs1",    bus.rs1_data,   64'h0);
        chk("rst_rs2",    bus.rs2_data,   64'h0);
        chk("rst_retire", bus.retire_cnt, 64'd0);
        chk("rst_fwdv",   {63'h0, bus.fwd_valid}, 64'd0);
        chk("rst_fwdrd",  {59'h0, bus.fwd_rd},    64'd0);
        chk("rst_fwdval", bus.fwd_value,  64'h0);

        // extension table: capture, check forward in fire cycle, read after write edge
        foreach (vecs[i]) begin
            drive_instr(vecs[i].sel, vecs[i].f3, vecs[i].data, vecs[i].rd);
            step();
            drive_idle();
            #1;
            chk($sformatf("ext%0d_fwdv", i),  {63'h0, bus.fwd_valid}, 64'd1);
            chk($sformatf("ext%0d_fwdrd", i), {59'h0, bus.fwd_rd}, {59'h0, vecs[i].rd});
            chk($sformatf("ext%0d_fwdval", i), bus.fwd_value, vecs[i].exp);
            step();
            bus.rs1_addr = vecs[i].rd;
            #1;
            chk($sformatf("ext%0d_reg", i), bus.rs1_data, vecs[i].exp);
            chk($sformatf("ext%0d_ret", i), bus.retire_cnt, 64'(i + 1));
            chk($sformatf("ext%0d_fwdoff", i), {63'h0, bus.fwd_valid}, 64'd0);
        end

        // x0 write: discarded but retired
        drive_instr(2'b00, 3'b000, 64'h1234, 5'd0);
        step();
        drive_idle();
        #1;
        chk("x0_fwdv", {63'h0, bus.fwd_valid}, 64'd0);
        step();
        bus.rs1_addr = 5'd0;
        #1;
        chk("x0_read",   bus.rs1_data,   64'h0);
        chk("x0_retire", bus.retire_cnt, 64'd14);

        // stalled entry writes and retires exactly once
        drive_instr(2'b00, 3'b000, 64'hAB, 5'd7);
        step();
        drive_idle();
        bus.stall = 1'b1;
        fwd_hits = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.fwd_valid) fwd_hits++;
            if (c == 3) bus.stall = 1'b0;
            step();
        end
        #1;
        if (bus.fwd_valid) fwd_hits++;
        chk("stall_fwd_cycles", 64'(fwd_hits), 64'd1);
        chk("stall_retire", bus.retire_cnt, 64'd15);
        bus.rs2_addr = 5'd7;
        #1;
        chk("stall_reg", bus.rs2_data, 64'hAB);

        // flush drops the incoming instruction; latched one still fires
        drive_instr(2'b00, 3'b000, 64'h111, 5'd20);
        step();
        drive_instr(2'b00, 3'b000, 64'h222, 5'd21);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        #1;
        chk("flush_fwdrd", {59'h0, bus.fwd_rd}, 64'd20);
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive_idle();
        #1;
        chk("flush_fwdv_after", {63'h0, bus.fwd_valid}, 64'd0);
        step();
        bus.rs1_addr = 5'd20;
        bus.rs2_addr = 5'd21;
        #1;
        chk("flush_old_reg", bus.rs1_data,   64'h111);
        chk("flush_new_reg", bus.rs2_data,   64'h0);
        chk("flush_retire",  bus.retire_cnt, 64'd16);

        // bypass timing on x9
        drive_instr(2'b00, 3'b000, 64'h33, 5'd9);
        step();
        drive_idle();
        step();
        drive_instr(2'b00, 3'b000, 64'h55, 5'd9);
        step();
        drive_idle();
        bus.rs2_addr = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_fire_cycle", bus.rs2_data, 64'h55);
`else
        chk("byp_fire_cycle", bus.rs2_data, 64'h33);
`endif
        step();
        chk("byp_next_cycle", bus.rs2_data, 64'h55);
        chk("byp_retire",     bus.retire_cnt, 64'd18);

        // reset while an entry is latched: no write, no count, array cleared
        drive_instr(2'b00, 3'b000, 64'h99, 5'd22);
        step();
        drive_idle();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        bus.rs1_addr = 5'd22;
        bus.rs2_addr = 5'd5;
        #1;
        chk("mrst_retire", bus.retire_cnt, 64'd0);
        chk("mrst_fwdv",   {63'h0, bus.fwd_valid}, 64'd0);
        step();
        chk("mrst_reg22",  bus.rs1_data,   64'h0);
        chk("mrst_reg5",   bus.rs2_data,   64'h0);
        chk("mrst_retire2", bus.retire_cnt, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

MEM/WB pipeline register, load-result extension and integer register file for the five-stage core. Captures the `mem` stage's write-back bundle, sign/zero-extends load data by `funct3`, and writes the 32×64 register file one cycle later. Serves the decode stage's two combinational read ports and exports the in-flight write-back for forwarding. Also keeps a 64-bit retired-instruction counter.

## Interface
- `XLEN`, 64, datapath width; must equal the shared `` `width `` span.
- `NREGS`, 32, register count; address width is log2(`NREGS`) = 5.
- `sys_clk` in 1: sole clock; all state updates on posedge.
- `sys_rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `mem` stage presents a real instruction.
- `in_wb_select` in 2: `00` ALU, `01` load, `10` pc+4, `11` ALU.
- `in_funct3` in 3: load width/sign code.
- `in_data` in XLEN: `write_back_data` from `mem`.
- `in_rd` in 5: destination register.
- `in_reg_write` in 1: instruction writes `rd`.
- `stall` in 1: hold the MEM/WB latch.
- `flush` in 1: drop the incoming instruction.
- `rs1_addr`, `rs2_addr` in 5 each: decode read addresses.
- `rs1_data`, `rs2_data` out XLEN each: read data; combinational.
- `fwd_valid` out 1: latched entry will write this cycle.
- `fwd_rd` out 5: its destination.
- `fwd_value` out XLEN: its extended value.
- `retire_cnt` out 64: count of retired instructions.

## Operation
- **Latch capture** at posedge, priority order:
  - `sys_rst`: clear all.
  - `flush`: `valid` ← 0.
  - `stall`: hold.
  - Otherwise: `valid` ← `in_valid`; `data`/`rd`/`funct3`/`wb_select`/`reg_write` ← inputs; `done` ← 0.
- **Extension** applies only when `wb_select == 01`; other selects pass `data` unchanged:
  - `000` LB: sign-extend [7:0].
  - `001` LH: sign-extend [15:0].
  - `010` LW: sign-extend [31:0].
  - `011` LD: pass through.
  - `100` LBU: zero-extend [7:0].
  - `101` LHU: zero-extend [15:0].
  - `110` LWU: zero-extend [31:0].
  - `111`: pass through.
- **Fire condition**: `fire = valid & ~done`. On a fire edge:
  - If `reg_write` and `rd != 0`: `regs[rd]` ← extended value.
  - `retire_cnt` += 1, whether or not the instruction writes.
  - `done` ← 1, so a stalled entry writes and retires exactly once.
- **x0**: writes are discarded; reads of address 0 always return 0.
- **Forwarding outputs**:
  - `fwd_valid = fire & reg_write & (rd != 0)`.
  - `fwd_rd` = latched `rd`; `fwd_value` = extended value.
  - When `fwd_valid` = 0, both are don't-care but deterministic (latched values).
- **Flush**: never cancels the already-latched entry, which is older; it still fires.
- **Reset mid-operation**: no register write and no count in the reset cycle; all 32 registers return to 0.
- `retire_cnt` wraps from 2^64−1 to 0.

## Timing
- Capture at edge N; extended value and `fwd_*` valid during cycle N→N+1.
- Register file written at edge N+1; plain read returns the new value from N+1 onward.
- **Reset values**: `valid` 0, `done` 0, `fwd_valid` 0, `fwd_rd` 0, `fwd_value` 0, `retire_cnt` 0, all registers 0, so `rs1_data` = `rs2_data` = 0.
- `stall` and `flush` together in one cycle: `flush` wins.
- Read ports are combinational, with no added latency.

## Configuration
- `WB_BYPASS_EN` defined: a read whose address equals `fwd_rd` while `fwd_valid` = 1 returns `fwd_value` in the same cycle (write-through).
- `WB_BYPASS_EN` undefined: reads return the array contents; the new value becomes visible after the write edge, and decode must stall one extra cycle.

## Structure
- **Package `wb_pkg`**:
  - `XLEN` and `NREGS`.
  - `wb_select` encodings: `WB_ALU`, `WB_LOAD`, `WB_PC4`.
  - `funct3` constants: `F3_LB` … `F3_LWU`.
  - Packed struct `wb_bundle_t` for the latch contents.
- **Sub-module `load_ext`**: combinational extender taking (`wb_select`, `funct3`, `data`) and returning the extended value; instantiated once.

## Test plan
- Reset held 2 cycles, then deasserted → all read ports 0, `retire_cnt` = 0, `fwd_valid` = 0.
- LB: `in_wb_select = 01`, `in_funct3 = 000`, `in_data = 0x..._0080`, `rd = 5` → `regs[5]` = 0xFFFF_FFFF_FFFF_FF80. Same value with LBU (`100`) → `0x80`.
- Write `rd = 0` with `0x1234` → `rs1_addr = 0` reads 0; `retire_cnt` increments by 1.
- Capture ALU result 0xAB into `rd = 7`, then hold `stall` for 3 cycles → exactly one write, `retire_cnt` +1 only, `fwd_valid` high for one cycle.
- `flush` asserted with a valid incoming instruction while the latched entry fires → latched entry writes; incoming is never written or counted.
- `WB_BYPASS_EN` on: `rs2_addr = 9` during the fire cycle of a write of 0x55 to x9 → `rs2_data` = 0x55 in that cycle. Off → old value, then 0x55 the next cycle.
